if_fetch_unit: RTL

- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Acts as the writer side of the IF/ID pipeline register: drives its write enable, pc_inc, pc_out and instr inputs.
- Holds fetched words across decode stalls, inserts flush bubbles on branch redirect, and stops fetching on HALT.

---
 rtl/if_pkg.sv | 23 ++
 rtl/fetch_pc_reg.sv | 44 ++++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      WAIT   = 3'd2,
      DRAIN  = 3'd3,
      HOLD   = 3'd4,
      HALTED = 3'd5
   } fetch_state_t;

   localparam int unsigned PC_STEP             = 2;
   localparam logic [15:0] DEFAULT_NOP_INSTR   = 16'h0000;
   localparam logic [3:0]  DEFAULT_HALT_OPCODE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with redirect load, sequential step and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
   import if_pkg::*;
#(
   parameter int                 DATA_W   = 16,
   parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_load_pc,
   input  logic              i_inc,
   output logic [DATA_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_pc_inc
);

   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] w_pc_inc;
   logic [DATA_W-1:0] w_load_aligned;

   // Instructions are halfword aligned, so a redirect target never keeps bit 0.
   assign w_load_aligned = i_load_pc & ~DATA_W'(1);
   assign w_pc_inc       = r_pc + DATA_W'(PC_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= w_load_aligned;
      end else if (i_inc) begin
         r_pc <= w_pc_inc;
      end
   end

   assign o_pc     = r_pc;
   assign o_pc_inc = w_pc_inc;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage; single-outstanding imem requests,
//               IF/ID writer with stall hold, redirect bubbles and HALT stop.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int                 DATA_W      = 16,
   parameter logic [DATA_W-1:0]  RESET_PC    = '0,
   parameter logic [3:0]         HALT_OPCODE = DEFAULT_HALT_OPCODE,
   parameter logic [DATA_W-1:0]  NOP_INSTR   = DATA_W'(DEFAULT_NOP_INSTR)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [DATA_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_valid,
   output logic              ifid_wen,
   output logic [DATA_W-1:0] ifid_pc_out,
   output logic [DATA_W-1:0] ifid_pc_inc,
   output logic [DATA_W-1:0] ifid_instr,
   output logic              halted
);

   fetch_state_t      r_state;
   fetch_state_t      w_next_state;
   logic [DATA_W-1:0] r_hold;

   logic [DATA_W-1:0] w_pc;
   logic [DATA_W-1:0] w_pc_plus;
   logic              w_pc_load;
   logic              w_pc_inc;
   logic              w_bubble;
   logic              w_deliver;
   logic [DATA_W-1:0] w_word;
   logic              w_hold_load;
   logic              w_hold_clr;

   fetch_pc_reg #(
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_pc_load),
      .i_load_pc (redirect_pc),
      .i_inc     (w_pc_inc),
      .o_pc      (w_pc),
      .o_pc_inc  (w_pc_plus)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
      end else if (w_hold_load) begin
         r_hold <= imem_rdata;
      end else if (w_hold_clr) begin
         r_hold <= '0;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_bubble     = 1'b0;
      w_deliver    = 1'b0;
      w_word       = '0;
      w_hold_load  = 1'b0;
      w_hold_clr   = 1'b0;
      w_pc_inc     = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = '0;
      ifid_wen     = 1'b0;
      ifid_pc_out  = '0;
      ifid_pc_inc  = '0;
      ifid_instr   = '0;

      // Redirect outranks stall, which outranks delivery, in every active state.
      case (r_state)
         IDLE: begin
            w_next_state = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               w_bubble = 1'b1;
            end else begin
               imem_req     = 1'b1;
               imem_addr    = w_pc;
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               w_bubble     = 1'b1;
               w_next_state = imem_valid ? FETCH : DRAIN;
            end else if (imem_valid) begin
               if (stall) begin
                  w_hold_load  = 1'b1;
                  w_next_state = HOLD;
               end else begin
                  w_deliver = 1'b1;
                  w_word    = imem_rdata;
               end
            end
         end
         DRAIN: begin
            // The stale response still has to land before a new request goes out.
            if (redirect) begin
               w_bubble = 1'b1;
            end
            if (imem_valid) begin
               w_next_state = FETCH;
            end
         end
         HOLD: begin
            if (redirect) begin
               w_bubble     = 1'b1;
               w_hold_clr   = 1'b1;
               w_next_state = FETCH;
            end else if (!stall) begin
               w_deliver  = 1'b1;
               w_word     = r_hold;
               w_hold_clr = 1'b1;
            end
         end
         HALTED: begin
            w_next_state = HALTED;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase

      if (w_bubble) begin
         ifid_wen   = 1'b1;
         ifid_instr = NOP_INSTR;
      end else if (w_deliver) begin
         ifid_wen    = 1'b1;
         ifid_pc_out = w_pc;
         ifid_pc_inc = w_pc_plus;
         ifid_instr  = w_word;
         if (w_word[DATA_W-1 -: 4] == HALT_OPCODE) begin
            w_next_state = HALTED;
         end else begin
            w_pc_inc     = 1'b1;
            w_next_state = FETCH;
         end
      end
   end

   assign w_pc_load = w_bubble;
   assign halted    = (r_state == HALTED);

endmodule
`default_nettype wire
